// File: rtl/bmult_accum.sv
// Sums multiplier products over caller-delimited groups into a saturating accumulator; results queue in a small FIFO.
// Latency: closing beat at cycle t gives r_valid at t+1 when the FIFO is empty; one beat is accepted every cycle.
// Backpressure: r_valid/r_ready drains the FIFO. The product side cannot stall, so a result pushed into a full FIFO is dropped and err_drop is set.
module bmult_accum #(
    parameter int PW    = 36,
    parameter int AW    = 48,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_valid,
    input  logic [PW-1:0] p_data,
    input  logic          p_last,
    output logic          r_valid,
    input  logic          r_ready,
    output logic [AW-1:0] r_data,
    output logic          r_sat,
    output logic [15:0]   r_beats,
    output logic          fifo_full,
    output logic          err_drop
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

    typedef enum logic {IDLE, ACC} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   acc, acc_nxt;
    logic            sat, sat_nxt;
    logic [15:0]     beats, beats_nxt;
    logic [AW:0]     sum_ext;
    logic            close;

    logic [AW-1:0]   mem_data  [DEPTH];
    logic            mem_sat   [DEPTH];
    logic [15:0]     mem_beats [DEPTH];
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic [PTRW:0]   count, count_nxt;
    logic            pop, push_ok, drop;

    // Accumulator next state: first beat of a group loads, later beats add with saturation.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        sat_nxt   = sat;
        beats_nxt = beats;
        close     = 1'b0;
        sum_ext   = {1'b0, acc} + (AW+1)'(p_data);
        if (p_valid) begin
            close     = p_last;
            state_nxt = p_last ? IDLE : ACC;
            if (state == IDLE) begin
                acc_nxt   = AW'(p_data);
                sat_nxt   = 1'b0;
                beats_nxt = 16'd1;
            end else begin
                if (sum_ext[AW]) begin
                    acc_nxt = '1;
                    sat_nxt = 1'b1;
                end else begin
                    acc_nxt = sum_ext[AW-1:0];
                end
                if (beats != 16'hFFFF) begin
                    beats_nxt = beats + 16'd1;
                end
            end
        end
    end

    // Accumulator and group state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            sat   <= 1'b0;
            beats <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            sat   <= sat_nxt;
            beats <= beats_nxt;
        end
    end

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_comb begin
        pop       = r_valid & r_ready;
        push_ok   = close & ((count != FULL_CNT) | pop);
        drop      = close & ~push_ok;
        count_nxt = count;
        if (push_ok & ~pop) begin
            count_nxt = count + 1'b1;
        end else if (pop & ~push_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    // FIFO pointers, occupancy, registered status flags and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            r_valid   <= 1'b0;
            fifo_full <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_nxt;
            r_valid   <= (count_nxt != '0);
            fifo_full <= (count_nxt == FULL_CNT);
            if (drop) begin
                err_drop <= 1'b1;
            end
        end
    end

    // Result storage; contents are only meaningful between the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_data[wr_ptr]  <= acc_nxt;
            mem_sat[wr_ptr]   <= sat_nxt;
            mem_beats[wr_ptr] <= beats_nxt;
        end
    end

    // Head entry driven straight from storage registers, forced to zero when empty.
    always_comb begin
        r_data  = '0;
        r_sat   = 1'b0;
        r_beats = '0;
        if (r_valid) begin
            r_data  = mem_data[rd_ptr];
            r_sat   = mem_sat[rd_ptr];
            r_beats = mem_beats[rd_ptr];
        end
    end

endmodule

// File: doc/bmult_accum.md
# bmult_accum

Product accumulator placed directly downstream of the one-stage 18x18 bit-heap multiplier. Consumes the 36-bit unsigned product stream, sums products over caller-delimited groups into an AW-bit saturating accumulator, and pushes one result per group into a small result FIFO drained through a valid/ready handshake. The multiplier cannot be stalled, so the FIFO absorbs results; a result that arrives when the FIFO is full is dropped and flagged.

## Interface

- PW, 36: product width; matches the multiplier output P.
- AW, 48: accumulator width, AW >= PW.
- DEPTH, 4: result FIFO depth, power of two, >= 2.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- p_valid  in  1  product beat valid this cycle.
- p_data  in  PW  unsigned product from the multiplier.
- p_last  in  1  beat closes the current group; ignored when p_valid=0.
- r_valid  out  1  FIFO head holds a result.
- r_ready  in  1  consumer accepts head when r_valid=1.
- r_data  out  AW  group sum, saturated.
- r_sat  out  1  group sum saturated.
- r_beats  out  16  beats in group, saturating at 0xFFFF.
- fifo_full  out  1  FIFO holds DEPTH entries.
- err_drop  out  1  sticky: a result was dropped; cleared only by rst.

## Operation

- States: IDLE (no open group) and ACC (group open). A beat with p_last=0 moves IDLE->ACC; a beat with p_last=1 closes the group and returns to IDLE. No beat: state held.
- First beat of a group loads acc = zero-extended p_data, beats = 1, sat = 0. Later beats: acc = acc + p_data, beats = beats + 1.
- Sum computed at AW+1 bits; carry-out set -> acc = 2^AW-1 and sat = 1 for the rest of the group. beats saturates at 0xFFFF, no wrap.
- Closing beat: the updated {acc, sat, beats}, including that beat's contribution, is pushed into the FIFO. A single beat with p_last=1 in IDLE forms a one-beat group.
- Push accepted when FIFO not full, or when full and a pop occurs the same cycle (r_valid & r_ready). Otherwise the result is discarded, err_drop set, FIFO unchanged; the accumulator still returns to IDLE.
- Pop on r_valid & r_ready; r_data/r_sat/r_beats always show the head entry (zero when empty).
- Push and pop in the same cycle: count unchanged, order preserved. Pointers wrap modulo DEPTH.
- p_data with p_valid=0 is ignored.

## Timing

- Reset values: r_valid=0, r_data=0, r_sat=0, r_beats=0, fifo_full=0, err_drop=0; state IDLE, acc=0, FIFO empty.
- rst mid-group: open group discarded, FIFO contents discarded; first beat after rst release starts a new group.
- Closing beat at cycle t -> r_valid=1 at t+1 when FIFO was empty (one-cycle latency). Beats accepted every cycle, no bubbles.
- r_valid, r_data, r_sat, r_beats, fifo_full are registered outputs; no combinational path from r_ready or p_* to any output.
- fifo_full reflects count after the edge; err_drop sets in cycle t+1 after a dropped push at t.
- Consumer may hold r_ready=1 continuously; one pop per cycle maximum.

## Test plan

- Reset: assert rst 2 cycles with p_valid=1 -> all outputs 0, no push; release, one beat 0x5 p_last=1 -> r_valid at next cycle, r_data=0x5, r_beats=1, r_sat=0.
- Group sum: three back-to-back beats 0xFFFF80001 (max 18x18 product), last on third -> r_data=0x2FFFE80003, r_beats=3, r_sat=0.
- Saturation with AW=38: five beats 0xFFFF80001 -> r_data=0x3FFFFFFFFF, r_sat=1, r_beats=5; next group of one beat 0x1 -> r_data=0x1, r_sat=0.
- FIFO overflow: r_ready=0, DEPTH+1 single-beat groups 1..5 -> fifo_full=1 after 4th, err_drop=1 after 5th; drain yields 1,2,3,4 in order.
- Full with simultaneous pop: fill FIFO, then r_ready=1 in the cycle of a closing beat -> push accepted, err_drop stays 0, fifo_full remains 1.
- Reset mid-group: two beats p_last=0, rst one cycle, one beat 0x7 p_last=1 -> r_data=0x7, r_beats=1.
